// File: rtl/prog_mem_if.sv
// Fetch/response/loader bundle for prog_mem_pipe.
// master = fetch/loader side, slave = memory.
interface prog_mem_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic                  flush;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_addr_err;
  logic                  rsp_par_err;
  logic                  load_we;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  init_done;

  modport master (
    output fetch_req, fetch_addr, flush, load_we, load_addr, load_data,
    input  fetch_ready, rsp_valid, rsp_data, rsp_addr_err, rsp_par_err, init_done
  );

  modport slave (
    input  fetch_req, fetch_addr, flush, load_we, load_addr, load_data,
    output fetch_ready, rsp_valid, rsp_data, rsp_addr_err, rsp_par_err, init_done
  );
endinterface

// File: rtl/prog_mem_pipe.sv
// Pipelined instruction memory: fetch with READ_LATENCY, flush, loader port, NOP-clear FSM.
// Define PROG_MEM_PARITY_EN to store and check an even-parity bit per word.
module prog_mem_pipe #(
  parameter int                    ADDR_WIDTH   = 10,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEM_DEPTH    = 1024,
  parameter int                    READ_LATENCY = 1,
  parameter int                    CLR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h00000013
) (
  input logic        clk,
  input logic        rst,
  prog_mem_if.slave  bus
);
`ifdef PROG_MEM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif
  localparam int L  = READ_LATENCY;
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [MW-1:0]         mem_q [MEM_DEPTH];

  function automatic logic [MW-1:0] enc(input logic [DATA_WIDTH-1:0] d);
`ifdef PROG_MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = bus.load_addr;
    wr_data = bus.load_data;
    case (state_q)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = NOP_WORD;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      default: wr_en = bus.load_we && ({1'b0, bus.load_addr} < DEPTH_W);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (CLR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array contents survive reset; only the clear FSM initialises them.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr[IW-1:0]] <= enc(wr_data);
  end

  logic                  accept, in_rng, perr_d;
  logic [MW-1:0]         rd_word;
  logic [DATA_WIDTH-1:0] data_d;

  assign bus.fetch_ready = !rst && (state_q == ST_READY) && !bus.load_we;
  assign bus.init_done   = !rst && (state_q == ST_READY);
  assign accept  = bus.fetch_req && bus.fetch_ready;
  assign in_rng  = {1'b0, bus.fetch_addr} < DEPTH_W;
  assign rd_word = mem_q[bus.fetch_addr[IW-1:0]];
  assign data_d  = in_rng ? rd_word[DATA_WIDTH-1:0] : NOP_WORD;
`ifdef PROG_MEM_PARITY_EN
  assign perr_d  = in_rng && ((^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH]);
`else
  assign perr_d  = 1'b0;
`endif

  logic [L:1]                 vld_pipe;
  logic [L:1][DATA_WIDTH-1:0] data_q;
  logic [L:1]                 aerr_q, perr_q;

  // Stages only load on a live entry, so the last stage holds the last delivered word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      data_q   <= '0;
      aerr_q   <= '0;
      perr_q   <= '0;
    end else begin
      vld_pipe[1] <= accept;
      if (accept) begin
        data_q[1] <= data_d;
        aerr_q[1] <= !in_rng;
        perr_q[1] <= perr_d;
      end
      for (int i = 2; i <= L; i++) begin
        vld_pipe[i] <= vld_pipe[i-1] && !bus.flush;
        if (vld_pipe[i-1] && !bus.flush) begin
          data_q[i] <= data_q[i-1];
          aerr_q[i] <= aerr_q[i-1];
          perr_q[i] <= perr_q[i-1];
        end
      end
    end
  end

  assign bus.rsp_valid    = vld_pipe[L];
  assign bus.rsp_data     = data_q[L];
  assign bus.rsp_addr_err = vld_pipe[L] && aerr_q[L];
  assign bus.rsp_par_err  = vld_pipe[L] && perr_q[L];
endmodule

// File: tb/tb_prog_mem_pipe.sv
// Scoreboard bench for prog_mem_pipe: driver pushes expected responses, monitor pops and compares.
module tb_prog_mem_pipe;
  localparam int AW = 10, DW = 32, DEPTH = 1000, LAT = 3;
  localparam logic [DW-1:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  prog_mem_pipe #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
    .READ_LATENCY(LAT), .CLR_ON_RESET(1), .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    bit            aerr;
    bit            perr;
    int            due;
  } exp_t;

  exp_t          q[$];
  int            n_cmp = 0, n_bad = 0, cyc = 0;
  logic [DW-1:0] mdl [0:(1<<AW)-1];
  bit            mdl_pbad [0:(1<<AW)-1];
  bit            mdl_ready = 1'b0;
  logic [DW-1:0] last_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares every cycle against the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", bus.rsp_valid, 0);
      chk("rst_data", bus.rsp_data, 0);
      chk("rst_aerr", bus.rsp_addr_err, 0);
      last_data = '0;
    end else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL missing_rsp: got no response expected data %0h due %0d (cycle %0d)",
                 q[0].data, q[0].due, cyc);
        q.delete(0);
      end
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got data %0h expected no response (cycle %0d)",
                   bus.rsp_data, cyc);
        end else begin : pop
          exp_t e;
          e = q.pop_front();
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_addr_err", bus.rsp_addr_err, e.aerr);
          chk("rsp_par_err", bus.rsp_par_err, e.perr);
          chk("rsp_cycle", cyc, e.due);
        end
        last_data = bus.rsp_data;
      end else begin
        chk("idle_aerr", bus.rsp_addr_err, 0);
        chk("idle_perr", bus.rsp_par_err, 0);
        chk("hold_data", bus.rsp_data, last_data);
      end
    end
  end

  // One cycle of stimulus; the reference model advances at the sampling edge.
  task automatic step(input bit req, input logic [AW-1:0] fa, input bit we,
                      input logic [AW-1:0] la, input logic [DW-1:0] ld, input bit fl);
    exp_t e;
    bus.fetch_req  = req;
    bus.fetch_addr = fa;
    bus.load_we    = we;
    bus.load_addr  = la;
    bus.load_data  = ld;
    bus.flush      = fl;
    @(negedge clk);
    chk("fetch_ready", bus.fetch_ready, !rst && mdl_ready && !we);
    chk("init_done", bus.init_done, !rst && mdl_ready);
    @(posedge clk);
    cyc++;
    if (!rst && mdl_ready) begin
      if (fl) while (q.size() > 0 && q[$].due >= cyc) q.delete(q.size() - 1);
      if (req && !we) begin
        if (int'(fa) < DEPTH) begin
          e.data = mdl[fa]; e.aerr = 1'b0; e.perr = mdl_pbad[fa];
        end else begin
          e.data = NOP; e.aerr = 1'b1; e.perr = 1'b0;
        end
        e.due = cyc + LAT - 1;
        q.push_back(e);
      end
      if (we && int'(la) < DEPTH) begin
        mdl[la]      = ld;
        mdl_pbad[la] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, 0, '0, '0, 0);
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    step(1, a, 0, '0, '0, 0);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(0, '0, 1, a, d, 0);
  endtask

  // Clear phase with junk traffic that must all be ignored.
  task automatic run_clear(input int n);
    for (int k = 0; k < n; k++)
      step($urandom_range(0, 1), AW'($urandom), $urandom_range(0, 1), AW'($urandom), $urandom, 0);
  endtask

  task automatic clear_done();
    for (int k = 0; k < (1 << AW); k++) begin
      mdl[k] = NOP;
      mdl_pbad[k] = 1'b0;
    end
    mdl_ready = 1'b1;
  endtask

  task automatic assert_rst(input int n);
    rst = 1'b1;
    q.delete();
    mdl_ready = 1'b0;
    idle(n);
    rst = 1'b0;
  endtask

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.fetch_req = 0; bus.fetch_addr = '0; bus.flush = 0;
    bus.load_we = 0; bus.load_addr = '0; bus.load_data = '0;
    idle(3);
    rst = 1'b0;
    run_clear(DEPTH);
    clear_done();

    fetch(5); fetch(0); fetch(AW'(DEPTH - 1));
    idle(2);

    load(3, 32'hDEADBEEF); load(4, 32'h12345678);
    fetch(3); fetch(4);
    idle(4);

    step(1, 7, 1, 7, 32'hAAAA5555, 0);
    fetch(7);
    idle(4);

    fetch(3); fetch(4); fetch(7);
    step(1, 2, 0, '0, '0, 1);
    idle(5);

    fetch(AW'(1010)); fetch(AW'(DEPTH));
    load(AW'(1010), 32'hCAFEF00D);
    fetch(AW'(1010));
    idle(4);

`ifdef PROG_MEM_PARITY_EN
    dut.mem_q[9] = dut.mem_q[9] ^ 33'h1;
    mdl[9] = mdl[9] ^ 32'h1;
    mdl_pbad[9] = 1'b1;
    fetch(9);
    idle(4);
`endif

    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 3) != 0, raddr(), $urandom_range(0, 4) == 0,
           raddr(), $urandom, $urandom_range(0, 15) == 0);
    idle(LAT + 2);

    load(3, 32'h01020304);
    fetch(3); fetch(4);
    assert_rst(2);
    run_clear(DEPTH / 2);
    assert_rst(2);
    run_clear(DEPTH);
    clear_done();
    fetch(3); fetch(4); fetch(7);
    idle(LAT + 2);

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
